// File: rtl/seq_down_timer_reload.sv
// Loadable down-counting timer with handshake load, optional auto-reload,
// one-cycle terminal-count pulse and a saturating expiry counter.
module seq_down_timer_reload #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             abort,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic [CNT_W-1:0] expire_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
  logic             load_acc;

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign load_ready = (state_q != RUN);
  assign q          = count_q;
  assign tc         = tc_q;
  assign expire_cnt = cnt_q;
  assign load_acc   = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    expire   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load_acc) begin
      count_d  = load_value;
      reload_d = load_value;
      if (load_value != '0) begin
        state_d = RUN;
      end else begin
        // A zero load expires on the spot.
        state_d = DONE;
        tc_d    = 1'b1;
        expire  = 1'b1;
      end
    end else if ((state_q == RUN) && en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d   = 1'b1;
        expire = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (expire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_down_timer_reload.sv
// Directed bench for seq_down_timer_reload: hand-computed vectors
// checked with immediate assertions one step after each rising edge.
module tb_seq_down_timer_reload;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       en;
  logic       auto_reload;
  logic       abort;
  logic       clr_cnt;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       tc;
  logic [3:0] expire_cnt;

  int vecs = 0;
  int errs = 0;

  seq_down_timer_reload #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .en         (en),
    .auto_reload(auto_reload),
    .abort      (abort),
    .clr_cnt    (clr_cnt),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .tc         (tc),
    .expire_cnt (expire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    en = 1'b0;
    auto_reload = 1'b0;
    abort = 1'b0;
    clr_cnt = 1'b0;
    step();
    step();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_tc", tc, 0);
    chk("rst_cnt", expire_cnt, 0);
    rst = 1'b0;

    // basic run: load 3
    load_valid = 1'b1; load_value = 8'd3; en = 1'b1;
    step();
    load_valid = 1'b0;
    chk("b_q3", q, 3);
    chk("b_busy", busy, 1);
    chk("b_ready0", load_ready, 0);
    chk("b_tc0", tc, 0);
    step();
    chk("b_q2", q, 2);
    step();
    chk("b_q1", q, 1);
    chk("b_tc1", tc, 0);
    step();
    chk("b_q0", q, 0);
    chk("b_tc", tc, 1);
    chk("b_done", done, 1);
    chk("b_cnt", expire_cnt, 1);
    chk("b_ready1", load_ready, 1);
    step();
    chk("b_tc_off", tc, 0);
    chk("b_done_hold", done, 1);
    chk("b_q_hold", q, 0);

    // en gating: load 5, en 1,0,0,1,1
    load_valid = 1'b1; load_value = 8'd5; en = 1'b0;
    step();
    load_valid = 1'b0;
    chk("g_q5", q, 5);
    en = 1'b1;
    step();
    chk("g_q4a", q, 4);
    en = 1'b0;
    load_valid = 1'b1; load_value = 8'd9;
    step();
    chk("g_q4b", q, 4);
    chk("g_busy_b", busy, 1);
    step();
    load_valid = 1'b0;
    chk("g_q4c", q, 4);
    chk("g_busy_c", busy, 1);
    en = 1'b1;
    step();
    chk("g_q3", q, 3);
    step();
    chk("g_q2", q, 2);
    chk("g_busy_e", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("g_abort_q", q, 0);
    chk("g_abort_busy", busy, 0);
    chk("g_abort_cnt", expire_cnt, 1);

    // auto-reload and saturation
    load_valid = 1'b1; load_value = 8'd2; auto_reload = 1'b1; en = 1'b1;
    step();
    load_valid = 1'b0;
    chk("a_q2", q, 2);
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("a_q", q, (k % 2 == 1) ? 1 : 2);
      chk("a_tc", tc, (k % 2 == 0) ? 1 : 0);
      chk("a_cnt", expire_cnt, (1 + k / 2 > 15) ? 15 : 1 + k / 2);
      chk("a_busy", busy, 1);
    end
    auto_reload = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("a_abort_cnt", expire_cnt, 15);
    chk("a_abort_tc", tc, 0);

    // clear, zero load, clear collision
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("z_clr", expire_cnt, 0);
    load_valid = 1'b1; load_value = 8'd0;
    step();
    load_valid = 1'b0;
    chk("z_done", done, 1);
    chk("z_tc", tc, 1);
    chk("z_cnt", expire_cnt, 1);
    chk("z_q", q, 0);
    step();
    chk("z_tc_off", tc, 0);
    load_valid = 1'b1; clr_cnt = 1'b1;
    step();
    load_valid = 1'b0; clr_cnt = 1'b0;
    chk("z_col_tc", tc, 1);
    chk("z_col_cnt", expire_cnt, 0);

    // abort priority over load
    load_valid = 1'b1; load_value = 8'd5; en = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    chk("p_q4", q, 4);
    abort = 1'b1; load_valid = 1'b1; load_value = 8'd7;
    step();
    abort = 1'b0;
    chk("p_q0", q, 0);
    chk("p_busy", busy, 0);
    chk("p_done", done, 0);
    chk("p_tc", tc, 0);
    en = 1'b0;
    step();
    load_valid = 1'b0;
    chk("p_q7", q, 7);
    chk("p_busy7", busy, 1);

    // async reset mid-run with nonzero counter
    abort = 1'b1;
    step();
    abort = 1'b0;
    load_valid = 1'b1; load_value = 8'd1; en = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    chk("r_pre_cnt", expire_cnt, 1);
    load_valid = 1'b1; load_value = 8'd7;
    step();
    load_valid = 1'b0;
    step();
    chk("r_q6", q, 6);
    en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("r_q", q, 0);
    chk("r_busy", busy, 0);
    chk("r_tc", tc, 0);
    chk("r_cnt", expire_cnt, 0);
    #2;
    rst = 1'b0;
    step();
    chk("r_ready", load_ready, 1);
    chk("r_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
